mpm_port_arbiter: RTL and testbench
===================================

// Module: mpm_port_arbiter
// PURPOSE
//   Shares one PORTS-port memory (multiport RAM of simple_ram banks) among REQS
//   requesters. Each cycle grants up to PORTS requests round-robin, drives one
//   memory port per grant, and routes 1-cycle-latency read data back to the
//   requester that issued the read. Sits between client engines and the RAM.
// PARAMETERS
//   WIDTH  8    data word width
//   DEPTH  256  memory words; AW = $clog2(DEPTH)
//   PORTS  2    memory ports; grants per cycle (1..REQS)
//   REQS   4    requesters (>= 2)
// PORTS
//   clk        in   1            clock, all state on posedge
//   rst        in   1            asynchronous, active-high reset
//   req_valid  in   1 [REQS]     request present
//   req_we     in   1 [REQS]     1 = write, 0 = read
//   req_addr   in   AW [REQS]    word address
//   req_d      in   WIDTH [REQS] write data
//   req_ready  out  1 [REQS]     grant; transfer when valid && ready
//   rsp_valid  out  1 [REQS]     read data valid
//   rsp_q      out  WIDTH [REQS] read data
//   mem_addr   out  AW [PORTS]   to RAM port address
//   mem_d      out  WIDTH [PORTS] to RAM write data
//   mem_en     out  1 [PORTS]    to RAM write enable
//   mem_q      in   WIDTH [PORTS] from RAM, registered (1-cycle latency)
// BEHAVIOUR
// - State: rr_ptr (clog2 REQS), rd_pend[PORTS] (valid + requester index).
// - Grant (comb.): scan r = rr_ptr, rr_ptr+1, ... mod REQS; grant r if
//   req_valid[r], fewer than PORTS grants so far, and, for a write, no
//   earlier grant this cycle is a write to the same addr. k-th grant -> port k.
// - req_ready[r] = granted; no dependence on ready inputs (none exist).
// - Port k granted: mem_addr=req_addr, mem_d=req_d, mem_en=req_we.
//   Port k idle: mem_addr=0, mem_d=0, mem_en=0.
// - rr_ptr <= (index of last grant + 1) mod REQS if any grant, else hold.
// - Read granted on port k at cycle t: rd_pend[k] <= {1, r}; at t+1
//   rsp_valid[r]=1, rsp_q[r]=mem_q[k]. Writes produce no response.
// - Read and write to same addr same cycle: read returns old data.
// - At most one read granted per requester per cycle, so responses never
//   collide. rsp_q[r]=0 whenever rsp_valid[r]=0.
// - Back-to-back: requester may be granted every cycle; throughput PORTS/cyc.
// - Reset (any time): rr_ptr=0, rd_pend cleared, rsp_valid=0, rsp_q=0;
//   in-flight reads are dropped, no response after reset. RAM not cleared.
// - All req_valid=0: all req_ready=0, all mem_en=0, rr_ptr holds.
// CONFIGURATION
//   MPM_ARB_STATS_EN defined: extra output stall_cnt  out  16 [REQS]; per
//   requester, +1 each cycle req_valid && !req_ready, saturates at 16'hFFFF,
//   reset to 0. Not defined: port and counters absent; behaviour otherwise
//   identical.
// TESTING
// - Reset, REQS=4/PORTS=2, all valid reads -> grants {0,1}, then {2,3},
//   then {0,1}; rr_ptr 0->2->0.
// - Req0 writes 0xA5 @0x10, next cycle req2 reads 0x10 -> rsp_valid[2] one
//   cycle after grant, rsp_q[2]=0xA5.
// - Req1 and req3 both write @0x20 same cycle, rr_ptr=0 -> req1 granted,
//   req3 ready=0, granted next cycle; final word = req3 data.
// - Same-cycle write 0x3C and read @0x30 (old 0x11) -> read returns 0x11.
// - Read granted, rst pulsed before response -> rsp_valid stays 0, rr_ptr=0.
// - STATS_EN: req3 held valid while 0..2 saturate 2 ports for 5 cycles ->
//   stall_cnt[3] counts stalled cycles; forced 70000 stalls -> 16'hFFFF.

Source files
------------

// File: rtl/mpm_port_arbiter_if.sv
// mpm_port_arbiter_if: requester and memory-port bundle for the multiport
// RAM arbiter. Master side is the client engines plus the RAM; slave side
// is the arbiter itself.
interface mpm_port_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PORTS = 2,
  parameter int REQS  = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [REQS-1:0]  req_valid;
  logic [REQS-1:0]  req_we;
  logic [AW-1:0]    req_addr [REQS];
  logic [WIDTH-1:0] req_d    [REQS];
  logic [REQS-1:0]  req_ready;
  logic [REQS-1:0]  rsp_valid;
  logic [WIDTH-1:0] rsp_q    [REQS];
  logic [AW-1:0]    mem_addr [PORTS];
  logic [WIDTH-1:0] mem_d    [PORTS];
  logic [PORTS-1:0] mem_en;
  logic [WIDTH-1:0] mem_q    [PORTS];

  modport master (
    output req_valid, req_we, req_addr, req_d, mem_q,
    input  req_ready, rsp_valid, rsp_q, mem_addr, mem_d, mem_en
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_d, mem_q,
    output req_ready, rsp_valid, rsp_q, mem_addr, mem_d, mem_en
  );
endinterface

// File: rtl/mpm_port_arbiter.sv
// mpm_port_arbiter: grants up to PORTS of REQS requests per cycle in
// round-robin order, drives one RAM port per grant and routes the
// 1-cycle-latency read data back to the issuing requester.
// Optional: define MPM_ARB_STATS_EN to add per-requester saturating
// stall counters (stall_cnt).
module mpm_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PORTS = 2,
  parameter int REQS  = 4
) (
  input  logic clk,
  input  logic rst,
  mpm_port_arbiter_if.slave bus
`ifdef MPM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt [REQS]
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(REQS);

  logic [RW-1:0]    rr_ptr;
  logic [RW-1:0]    rr_nxt;
  logic [RW-1:0]    last_idx;
  logic [REQS-1:0]  gnt;
  logic [PORTS-1:0] p_vld;
  logic [PORTS-1:0] p_we;
  logic [RW-1:0]    p_idx  [PORTS];
  logic [AW-1:0]    p_addr [PORTS];
  logic [WIDTH-1:0] p_d    [PORTS];
  logic [PORTS-1:0] rd_vld;
  logic [RW-1:0]    rd_idx [PORTS];
  int unsigned      gcnt;
  int unsigned      r;
  logic             clash;

  // Round-robin scan from rr_ptr; the k-th grant claims memory port k.
  // A write is skipped if an earlier grant this cycle writes the same word.
  always_comb begin
    gnt      = '0;
    p_vld    = '0;
    p_we     = '0;
    last_idx = '0;
    gcnt     = 0;
    r        = 0;
    clash    = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      p_idx[k]  = '0;
      p_addr[k] = '0;
      p_d[k]    = '0;
    end
    for (int unsigned i = 0; i < REQS; i++) begin
      r = 32'(rr_ptr) + i;
      if (r >= REQS) r = r - REQS;
      clash = 1'b0;
      for (int unsigned k = 0; k < PORTS; k++)
        if (k < gcnt && p_we[k] && p_addr[k] == bus.req_addr[r]) clash = 1'b1;
      if (bus.req_valid[r] && gcnt < PORTS && !(bus.req_we[r] && clash)) begin
        gnt[r]       = 1'b1;
        p_vld[gcnt]  = 1'b1;
        p_we[gcnt]   = bus.req_we[r];
        p_idx[gcnt]  = RW'(r);
        p_addr[gcnt] = bus.req_addr[r];
        p_d[gcnt]    = bus.req_d[r];
        last_idx     = RW'(r);
        gcnt         = gcnt + 1;
      end
    end
  end

  // Memory ports mirror the granted request; idle ports are driven to zero.
  always_comb begin
    bus.req_ready = gnt;
    for (int unsigned k = 0; k < PORTS; k++) begin
      bus.mem_addr[k] = p_addr[k];
      bus.mem_d[k]    = p_d[k];
      bus.mem_en[k]   = p_vld[k] & p_we[k];
    end
  end

  // Pointer advances to one past the last granted requester (mod REQS).
  always_comb begin
    rr_nxt = (32'(last_idx) == REQS - 1) ? '0 : last_idx + 1'b1;
  end

  // Round-robin pointer and per-port pending-read tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rd_vld <= '0;
      for (int unsigned k = 0; k < PORTS; k++) rd_idx[k] <= '0;
    end else begin
      if (|gnt) rr_ptr <= rr_nxt;
      for (int unsigned k = 0; k < PORTS; k++) begin
        rd_vld[k] <= p_vld[k] & ~p_we[k];
        rd_idx[k] <= p_idx[k];
      end
    end
  end

  // Route registered RAM data back to the requester that issued the read.
  always_comb begin
    bus.rsp_valid = '0;
    for (int unsigned q = 0; q < REQS; q++) bus.rsp_q[q] = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (rd_vld[k]) begin
        bus.rsp_valid[rd_idx[k]] = 1'b1;
        bus.rsp_q[rd_idx[k]]     = bus.mem_q[k];
      end
    end
  end

`ifdef MPM_ARB_STATS_EN
  // Saturating count of cycles each requester waited with a valid request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned q = 0; q < REQS; q++) stall_cnt[q] <= '0;
    end else begin
      for (int unsigned q = 0; q < REQS; q++)
        if (bus.req_valid[q] && !gnt[q] && stall_cnt[q] != '1)
          stall_cnt[q] <= stall_cnt[q] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mpm_port_arbiter.sv
// tb_mpm_port_arbiter: directed and random traffic against a queue-based
// round-robin reference model with a shadow memory.
module tb_mpm_port_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int PORTS = 2;
  localparam int REQS  = 4;
  localparam int AW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mpm_port_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) bus ();

`ifdef MPM_ARB_STATS_EN
  logic [15:0] stall_cnt [REQS];
  int          m_stall   [REQS];
`endif

  mpm_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MPM_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // RAM environment: registered read, old data on same-cycle write.
  logic [WIDTH-1:0] ram [DEPTH] = '{default: 8'h00};
  always @(posedge clk) begin
    for (int k = 0; k < PORTS; k++) begin
      bus.mem_q[k] <= ram[bus.mem_addr[k]];
      if (bus.mem_en[k]) ram[bus.mem_addr[k]] <= bus.mem_d[k];
    end
  end

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: 8'h00};
  int               m_rr;
  logic [REQS-1:0]  m_rsp_v;
  logic [WIDTH-1:0] m_rsp_q [REQS];

  logic [REQS-1:0]  obs_ready;
  logic [REQS-1:0]  obs_rsp_v;
  logic [WIDTH-1:0] obs_rsp_q [REQS];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_valid[r] = v;
    bus.req_we[r]    = we;
    bus.req_addr[r]  = a;
    bus.req_d[r]     = d;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < REQS; r++) set_req(r, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    m_rr    = 0;
    m_rsp_v = '0;
    for (int r = 0; r < REQS; r++) m_rsp_q[r] = '0;
`ifdef MPM_ARB_STATS_EN
    for (int r = 0; r < REQS; r++) m_stall[r] = 0;
`endif
  endtask

  // Called just after a posedge; pulses reset well before the next sample.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: sample and compare at negedge, advance model at posedge.
  task automatic cycle();
    int               gr[$];
    logic [REQS-1:0]  exp_ready;
    logic [REQS-1:0]  nv;
    logic [WIDTH-1:0] nq [REQS];
    int               rr_i;
    bit               clash;
    exp_ready = '0;
    nv        = '0;
    for (int r = 0; r < REQS; r++) nq[r] = '0;
    @(negedge clk);
    obs_ready = bus.req_ready;
    obs_rsp_v = bus.rsp_valid;
    for (int r = 0; r < REQS; r++) obs_rsp_q[r] = bus.rsp_q[r];

    for (int i = 0; i < REQS; i++) begin
      rr_i  = (m_rr + i) % REQS;
      clash = 1'b0;
      foreach (gr[j])
        if (bus.req_we[rr_i] && bus.req_we[gr[j]] && bus.req_addr[gr[j]] == bus.req_addr[rr_i])
          clash = 1'b1;
      if (bus.req_valid[rr_i] && gr.size() < PORTS && !clash) begin
        gr.push_back(rr_i);
        exp_ready[rr_i] = 1'b1;
      end
    end

    check("req_ready", 32'(obs_ready), 32'(exp_ready));
    for (int k = 0; k < PORTS; k++) begin
      if (k < gr.size()) begin
        check("mem_en",   32'(bus.mem_en[k]),   32'(bus.req_we[gr[k]]));
        check("mem_addr", 32'(bus.mem_addr[k]), 32'(bus.req_addr[gr[k]]));
        check("mem_d",    32'(bus.mem_d[k]),    32'(bus.req_d[gr[k]]));
      end else begin
        check("idle_en",   32'(bus.mem_en[k]),   32'd0);
        check("idle_addr", 32'(bus.mem_addr[k]), 32'd0);
        check("idle_d",    32'(bus.mem_d[k]),    32'd0);
      end
    end
    check("rsp_valid", 32'(obs_rsp_v), 32'(m_rsp_v));
    for (int r = 0; r < REQS; r++)
      check("rsp_q", 32'(obs_rsp_q[r]), 32'(m_rsp_q[r]));
`ifdef MPM_ARB_STATS_EN
    for (int r = 0; r < REQS; r++) begin
      check("stall_cnt", 32'(stall_cnt[r]), 32'(m_stall[r]));
      if (bus.req_valid[r] && !exp_ready[r] && m_stall[r] < 65535) m_stall[r]++;
    end
`endif

    foreach (gr[k])
      if (!bus.req_we[gr[k]]) begin
        nv[gr[k]] = 1'b1;
        nq[gr[k]] = ref_mem[bus.req_addr[gr[k]]];
      end
    foreach (gr[k])
      if (bus.req_we[gr[k]]) ref_mem[bus.req_addr[gr[k]]] = bus.req_d[gr[k]];
    if (gr.size() > 0) m_rr = (gr[gr.size()-1] + 1) % REQS;

    @(posedge clk);
    #1;
    m_rsp_v = nv;
    for (int r = 0; r < REQS; r++) m_rsp_q[r] = nq[r];
  endtask

  initial begin
    model_reset();
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_mem_en",    32'(bus.mem_en),    32'd0);
    rst = 1'b0;

    // All requesters reading: grants {0,1}, {2,3}, {0,1}.
    for (int r = 0; r < REQS; r++) set_req(r, 1'b1, 1'b0, AW'(r), '0);
    cycle(); check("rr_gnt0", 32'(obs_ready), 32'h3);
    cycle(); check("rr_gnt1", 32'(obs_ready), 32'hC);
    cycle(); check("rr_gnt2", 32'(obs_ready), 32'h3);
    clear_reqs();
    cycle();

    // Write then read-back through another requester.
    set_req(0, 1'b1, 1'b1, 8'h10, 8'hA5);
    cycle(); check("wr_gnt", 32'(obs_ready), 32'h1);
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 8'h10, '0);
    cycle(); check("rd_gnt", 32'(obs_ready), 32'h4);
    clear_reqs();
    cycle();
    check("rd_rsp_v", 32'(obs_rsp_v), 32'h4);
    check("rd_rsp_q", 32'(obs_rsp_q[2]), 32'hA5);

    // Two writes to the same word: lower-ranked one waits a cycle.
    do_reset();
    set_req(1, 1'b1, 1'b1, 8'h20, 8'h77);
    set_req(3, 1'b1, 1'b1, 8'h20, 8'h99);
    cycle(); check("ww_first", 32'(obs_ready), 32'h2);
    set_req(1, 1'b0, 1'b0, '0, '0);
    cycle(); check("ww_second", 32'(obs_ready), 32'h8);
    clear_reqs();
    set_req(0, 1'b1, 1'b0, 8'h20, '0);
    cycle();
    clear_reqs();
    cycle(); check("ww_final", 32'(obs_rsp_q[0]), 32'h99);

    // Same-cycle write and read of one word: read sees the old value.
    set_req(0, 1'b1, 1'b1, 8'h30, 8'h11);
    cycle();
    set_req(0, 1'b1, 1'b1, 8'h30, 8'h3C);
    set_req(1, 1'b1, 1'b0, 8'h30, '0);
    cycle(); check("rw_gnt", 32'(obs_ready), 32'h3);
    clear_reqs();
    set_req(2, 1'b1, 1'b0, 8'h30, '0);
    cycle(); check("rw_old", 32'(obs_rsp_q[1]), 32'h11);
    clear_reqs();
    cycle(); check("rw_new", 32'(obs_rsp_q[2]), 32'h3C);

    // Reset with a read in flight: response dropped, pointer back at 0.
    set_req(3, 1'b1, 1'b0, 8'h30, '0);
    cycle(); check("fl_gnt", 32'(obs_ready), 32'h8);
    do_reset();
    clear_reqs();
    cycle(); check("fl_drop", 32'(obs_rsp_v), 32'd0);
    for (int r = 0; r < REQS; r++) set_req(r, 1'b1, 1'b0, AW'(r), '0);
    cycle(); check("fl_rr0", 32'(obs_ready), 32'h3);

    // Random traffic on a small address window to provoke write clashes.
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < REQS; r++)
        set_req(r, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                AW'(8'h40 + $urandom_range(0, 3)), WIDTH'($urandom));
      if (n == 200) do_reset();
      cycle();
    end
    clear_reqs();
    cycle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
